// File: rtl/game_round_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// game_round_ctrl_pkg : FSM state encoding and game_state summary codes
// Revision 1.0
// ============================================================================
package game_round_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_SERVE     = 3'd2,
      ST_PLAY      = 3'd3,
      ST_WON       = 3'd4,
      ST_LOST      = 3'd5
   } state_t;

   localparam logic [1:0] GS_IDLE = 2'b00;
   localparam logic [1:0] GS_PLAY = 2'b01;
   localparam logic [1:0] GS_WON  = 2'b10;
   localparam logic [1:0] GS_OVER = 2'b11;

   localparam int         c_TIMER_W     = 10;
   localparam logic [9:0] c_SECOND_LOAD = 10'd999;

   function automatic logic [1:0] state_code(input state_t s);
      logic [1:0] code;
      code = GS_IDLE;
      case (s)
         ST_IDLE, ST_COUNTDOWN: code = GS_IDLE;
         ST_SERVE, ST_PLAY:     code = GS_PLAY;
         ST_WON:                code = GS_WON;
         ST_LOST:               code = GS_OVER;
         default:               code = GS_IDLE;
      endcase
      return code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/game_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// game_round_ctrl_if : button/hit-detect inputs and display/ball outputs
// Revision 1.0
// ============================================================================
interface game_round_ctrl_if;

   logic       tick_1ms;
   logic       start_btn;
   logic       hit;
   logic       miss;
   logic [4:0] player_score;
   logic [4:0] miss_count;
   logic [1:0] game_state;
   logic [3:0] countdown_digit;
   logic       serve_req;

   modport master (
      output tick_1ms, start_btn, hit, miss,
      input  player_score, miss_count, game_state, countdown_digit, serve_req
   );

   modport slave (
      input  tick_1ms, start_btn, hit, miss,
      output player_score, miss_count, game_state, countdown_digit, serve_req
   );

endinterface
`default_nettype wire

// File: rtl/game_round_ctrl_ms_down_timer.sv
`default_nettype none
// ============================================================================
// game_round_ctrl_ms_down_timer : loadable ms down-counter with zero flag
// Revision 1.0
// ============================================================================
module game_round_ctrl_ms_down_timer #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] r_count;

   // Load wins over a coincident tick; the count parks at zero until reloaded.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (tick && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/game_round_ctrl.sv
`default_nettype none
// ============================================================================
// game_round_ctrl : game session sequencer (countdown, serve, rally, win/lose)
// Revision 1.0
// ============================================================================
module game_round_ctrl
   import game_round_ctrl_pkg::*;
#(
   parameter int WIN_SCORE     = 9,
   parameter int MISS_LIMIT    = 9,
   parameter int COUNTDOWN_SEC = 3,
   parameter int SERVE_MS      = 500
) (
   input  logic             clk,
   input  logic             reset,
   game_round_ctrl_if.slave bus
);

   localparam logic [4:0]           c_WIN_SCORE  = 5'(WIN_SCORE);
   localparam logic [4:0]           c_MISS_LIMIT = 5'(MISS_LIMIT);
   localparam logic [3:0]           c_CD_SEC     = 4'(COUNTDOWN_SEC);
   localparam logic [c_TIMER_W-1:0] c_SERVE_LOAD = c_TIMER_W'(SERVE_MS - 1);

   state_t               r_state;
   logic                 r_start_q;
   logic [4:0]           r_score;
   logic [4:0]           r_misses;
   logic [3:0]           r_digit;
   logic [1:0]           r_game_state;
   logic                 r_serve_req;

   logic                 w_start_edge;
   logic                 w_phase_done;
   logic                 w_tmr_zero;
   logic                 w_tmr_load;
   logic [c_TIMER_W-1:0] w_tmr_val;
   logic [4:0]           w_score_inc;
   logic [4:0]           w_misses_inc;

   assign w_start_edge = bus.start_btn & ~r_start_q;
   assign w_phase_done = bus.tick_1ms & w_tmr_zero;
   assign w_score_inc  = r_score + 5'd1;
   assign w_misses_inc = r_misses + 5'd1;

   // Timer reloads happen on the same edge as the FSM transition they belong to.
   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_val  = c_SECOND_LOAD;
      case (r_state)
         ST_IDLE, ST_WON, ST_LOST: begin
            w_tmr_load = w_start_edge;
         end
         ST_COUNTDOWN: begin
            w_tmr_load = w_phase_done;
            w_tmr_val  = (r_digit == 4'd1) ? c_SERVE_LOAD : c_SECOND_LOAD;
         end
         ST_PLAY: begin
            w_tmr_load = ~bus.hit & bus.miss & (w_misses_inc != c_MISS_LIMIT);
            w_tmr_val  = c_SERVE_LOAD;
         end
         default: begin
            w_tmr_load = 1'b0;
         end
      endcase
   end

   game_round_ctrl_ms_down_timer #(
      .WIDTH (c_TIMER_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .tick     (bus.tick_1ms),
      .load     (w_tmr_load),
      .load_val (w_tmr_val),
      .zero     (w_tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_start_q    <= 1'b0;
         r_score      <= '0;
         r_misses     <= '0;
         r_digit      <= '0;
         r_game_state <= GS_IDLE;
         r_serve_req  <= 1'b0;
      end else begin
         r_start_q   <= bus.start_btn;
         r_serve_req <= 1'b0;
         case (r_state)
            ST_IDLE, ST_WON, ST_LOST: begin
               if (w_start_edge) begin
                  r_score      <= '0;
                  r_misses     <= '0;
                  r_digit      <= c_CD_SEC;
                  r_state      <= ST_COUNTDOWN;
                  r_game_state <= state_code(ST_COUNTDOWN);
               end
            end
            ST_COUNTDOWN: begin
               if (w_phase_done) begin
                  if (r_digit == 4'd1) begin
                     r_digit      <= '0;
                     r_state      <= ST_SERVE;
                     r_game_state <= state_code(ST_SERVE);
                  end else begin
                     r_digit <= r_digit - 4'd1;
                  end
               end
            end
            ST_SERVE: begin
               if (w_phase_done) begin
                  r_state      <= ST_PLAY;
                  r_game_state <= state_code(ST_PLAY);
                  r_serve_req  <= 1'b1;
               end
            end
            ST_PLAY: begin
               // A hit coinciding with a miss takes precedence; the miss is lost.
               if (bus.hit) begin
                  r_score <= w_score_inc;
                  if (w_score_inc == c_WIN_SCORE) begin
                     r_state      <= ST_WON;
                     r_game_state <= state_code(ST_WON);
                  end
               end else if (bus.miss) begin
                  r_misses <= w_misses_inc;
                  if (w_misses_inc == c_MISS_LIMIT) begin
                     r_state      <= ST_LOST;
                     r_game_state <= state_code(ST_LOST);
                  end else begin
                     r_state      <= ST_SERVE;
                     r_game_state <= state_code(ST_SERVE);
                  end
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_game_state <= GS_IDLE;
            end
         endcase
      end
   end

   assign bus.player_score    = r_score;
   assign bus.miss_count      = r_misses;
   assign bus.game_state      = r_game_state;
   assign bus.countdown_digit = r_digit;
   assign bus.serve_req       = r_serve_req;

endmodule
`default_nettype wire
